// File: rtl/alu_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : alu_input_loader
// Description : Latches ALU operands A, B and the operation code from board
//               switches under control of three push buttons. Buttons and
//               switches are brought into the clock domain with two-flop
//               synchronizers; each button drives a debounced state whose
//               rising edge produces a one-cycle load pulse.
//
//               Optional debounce filter: define ALU_INPUT_LOADER_DEBOUNCE_EN
//               to build per-button stability counters. Without it the
//               debounced state simply follows the synchronized level.
//
// Ports       : i_clk       clock, rising edge
//               i_reset     synchronous active-high reset
//               i_sw        switch values (asynchronous)
//               i_btn_a     load A button (raw, bouncing, active high)
//               i_btn_b     load B button
//               i_btn_op    load OP button
//               o_a, o_b    latched operands
//               o_op        latched operation code (low BITS_OP switch bits)
//               o_loaded    loaded-since-reset flags {op, b, a}
//               o_valid     one-cycle pulse: set complete and just changed
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_input_loader #(
    parameter int BITS_DATA       = 8,
    parameter int BITS_OP         = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [BITS_DATA-1:0] i_sw,
    input  logic                 i_btn_a,
    input  logic                 i_btn_b,
    input  logic                 i_btn_op,
    output logic [BITS_DATA-1:0] o_a,
    output logic [BITS_DATA-1:0] o_b,
    output logic [BITS_OP-1:0]   o_op,
    output logic [2:0]           o_loaded,
    output logic                 o_valid
);

    // Reject configurations outside the counter's representable range.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 24'hFFFFFF) begin : g_bad_cfg
        $error("alu_input_loader: DEBOUNCE_CYCLES out of range");
    end

    // Button index order throughout: 0 = A, 1 = B, 2 = OP.
    logic [2:0]           w_btn_raw;
    logic [2:0]           r_btn_s1;
    logic [2:0]           r_btn_s2;
    logic [BITS_DATA-1:0] r_sw_s1;
    logic [BITS_DATA-1:0] r_sw_s2;
    logic [2:0]           w_db;
    logic [2:0]           r_db_d;
    logic [2:0]           w_load;
    logic [2:0]           w_loaded_next;
    logic [BITS_DATA-1:0] r_a;
    logic [BITS_DATA-1:0] r_b;
    logic [BITS_OP-1:0]   r_op;
    logic [2:0]           r_loaded;
    logic                 r_valid;

    assign w_btn_raw = {i_btn_op, i_btn_b, i_btn_a};

    // Two-flop synchronizers for buttons and switches.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= i_sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
    localparam logic [23:0] c_db_limit = 24'(DEBOUNCE_CYCLES);

    // The counter measures how many consecutive cycles the synchronized level
    // has disagreed with the debounced state; the state flips on the cycle
    // after DEBOUNCE_CYCLES disagreeing samples have been seen.
    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        logic [23:0] r_cnt;
        logic        r_state;

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
            end else if (r_btn_s2[gi] != r_state) begin
                if (r_cnt == c_db_limit) begin
                    r_state <= r_btn_s2[gi];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 24'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_db[gi] = r_state;
    end
`else
    // Debounced state is a plain register copy of the synchronized level.
    for (genvar gi = 0; gi < 3; gi++) begin : g_no_debounce
        logic r_state;

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_state <= 1'b0;
            end else begin
                r_state <= r_btn_s2[gi];
            end
        end

        assign w_db[gi] = r_state;
    end
`endif

    // Rising edge of the debounced state is the load pulse; falling edges
    // and held levels produce nothing.
    assign w_load        = w_db & ~r_db_d;
    assign w_loaded_next = r_loaded | w_load;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_db_d   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_loaded <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_db_d <= w_db;
            // Simultaneous pulses all apply with the same switch sample.
            if (w_load[0]) r_a  <= r_sw_s2;
            if (w_load[1]) r_b  <= r_sw_s2;
            if (w_load[2]) r_op <= r_sw_s2[BITS_OP-1:0];
            r_loaded <= w_loaded_next;
            r_valid  <= (|w_load) && (w_loaded_next == 3'b111);
        end
    end

    assign o_a      = r_a;
    assign o_b      = r_b;
    assign o_op     = r_op;
    assign o_loaded = r_loaded;
    assign o_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_input_loader
// Description : Self-checking bench for alu_input_loader. A behavioural model
//               holds the expected operand set; presses are applied with
//               clean levels (and one bouncing sequence when the debounce
//               filter is built) and every result is checked at the exact
//               load edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_input_loader;

    localparam int DB = 4;
`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = '0;
    logic       btn_a = 1'b0;
    logic       btn_b = 1'b0;
    logic       btn_op = 1'b0;
    logic [7:0] o_a;
    logic [7:0] o_b;
    logic [5:0] o_op;
    logic [2:0] o_loaded;
    logic       o_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the latched state.
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [5:0] m_op = '0;
    logic [2:0] m_loaded = '0;

    alu_input_loader #(
        .BITS_DATA      (8),
        .BITS_OP        (6),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_sw    (sw),
        .i_btn_a (btn_a),
        .i_btn_b (btn_b),
        .i_btn_op(btn_op),
        .o_a     (o_a),
        .o_b     (o_b),
        .o_op    (o_op),
        .o_loaded(o_loaded),
        .o_valid (o_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [2:0] m);
        btn_a  = m[0];
        btn_b  = m[1];
        btn_op = m[2];
    endtask

    // Clean press of the buttons in mask, held for hold cycles. Edge k=1 is
    // the first edge sampling the press; the load lands at edge k=LAT+1.
    task automatic do_press(input logic [2:0] mask, input logic [7:0] swv,
                            input int hold, input string tag);
        logic [7:0] na, nb;
        logic [5:0] nop;
        logic [2:0] nl;
        logic       ev;
        int         vcount;
        sw = swv;
        repeat (3) tick();
        na  = mask[0] ? swv : m_a;
        nb  = mask[1] ? swv : m_b;
        nop = mask[2] ? swv[5:0] : m_op;
        nl  = m_loaded | mask;
        ev  = (nl == 3'b111);
        vcount = 0;
        set_btns(mask);
        for (int k = 1; k <= hold + LAT + 3; k++) begin
            tick();
            if (o_valid) vcount++;
            if (k == LAT) begin
                n_checks++;
                if (o_loaded !== m_loaded || o_valid !== 1'b0)
                    $display("FAIL %s early: loaded=%b valid=%b want loaded=%b valid=0",
                             tag, o_loaded, o_valid, m_loaded);
                else n_pass++;
            end
            if (k == LAT + 1) begin
                n_checks++;
                if (o_a !== na || o_b !== nb || o_op !== nop)
                    $display("FAIL %s regs: a=%h b=%h op=%h want a=%h b=%h op=%h",
                             tag, o_a, o_b, o_op, na, nb, nop);
                else n_pass++;
                n_checks++;
                if (o_loaded !== nl || o_valid !== ev)
                    $display("FAIL %s flags: loaded=%b valid=%b want loaded=%b valid=%b",
                             tag, o_loaded, o_valid, nl, ev);
                else n_pass++;
            end
            if (k == hold) set_btns(3'b000);
        end
        n_checks++;
        if (vcount !== (ev ? 1 : 0))
            $display("FAIL %s valid_count: got %0d want %0d", tag, vcount, ev ? 1 : 0);
        else n_pass++;
        m_a = na; m_b = nb; m_op = nop; m_loaded = nl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btns(3'b000);
        sw = 8'($urandom);
        repeat (4) tick();
        n_checks++;
        if (o_a !== 8'h00 || o_b !== 8'h00 || o_op !== 6'h00)
            $display("FAIL reset_regs: a=%h b=%h op=%h want 00 00 00", o_a, o_b, o_op);
        else n_pass++;
        n_checks++;
        if (o_loaded !== 3'b000 || o_valid !== 1'b0)
            $display("FAIL reset_flags: loaded=%b valid=%b want 000 0", o_loaded, o_valid);
        else n_pass++;
        rst = 1'b0;
        m_a = '0; m_b = '0; m_op = '0; m_loaded = '0;
        repeat (3) tick();
    endtask

    task automatic test_single_a();
        do_press(3'b001, 8'h35, LAT + 3, "single_a");
    endtask

    task automatic test_simultaneous();
        do_press(3'b011, 8'hAA, LAT + 3, "simul_ab");
    endtask

    task automatic test_full_set();
        do_press(3'b001, 8'h05, LAT + 3, "full_a");
        do_press(3'b010, 8'hFB, LAT + 3, "full_b");
        do_press(3'b100, 8'h20, LAT + 3, "full_op");
    endtask

    task automatic test_reload_same();
        do_press(3'b100, 8'h20, LAT + 3, "reload_same");
    endtask

    task automatic test_held();
        do_press(3'b001, 8'h9C, 50, "held_a");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            do_press(3'($urandom_range(1, 7)), 8'($urandom),
                     LAT + 3 + int'($urandom_range(0, 6)), "random");
        end
    endtask

`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
    // Bouncing B press: 1,0,1,0 then held; only the stable run may load.
    task automatic test_bounce();
        logic early_ok;
        do_press(3'b010, 8'hF0, LAT + 3, "bounce_pre");
        sw = 8'h0F;
        repeat (3) tick();
        early_ok = 1'b1;
        for (int k = 1; k <= 5 + LAT + 4; k++) begin
            case (k)
                1: btn_b = 1'b1;
                2: btn_b = 1'b0;
                3: btn_b = 1'b1;
                4: btn_b = 1'b0;
                5: btn_b = 1'b1;
                default: ;
            endcase
            tick();
            if (k < 5 + LAT && o_b !== 8'hF0) early_ok = 1'b0;
            if (k == 5 + LAT) begin
                n_checks++;
                if (!early_ok)
                    $display("FAIL bounce_early: o_b changed before stable window");
                else n_pass++;
                n_checks++;
                if (o_b !== 8'h0F)
                    $display("FAIL bounce_load: o_b=%h want 0f", o_b);
                else n_pass++;
            end
        end
        n_checks++;
        if (o_b !== 8'h0F)
            $display("FAIL bounce_single: o_b=%h want 0f", o_b);
        else n_pass++;
        btn_b = 1'b0;
        m_b = 8'h0F;
        m_loaded[1] = 1'b1;
        repeat (LAT + 3) tick();
    endtask
`endif

    // Reset coincident with an OP load pulse: reset wins, nothing reloads.
    task automatic test_reset_override();
        int vcount;
        sw = 8'h3C;
        repeat (3) tick();
        set_btns(3'b100);
        vcount = 0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (o_valid) vcount++;
        end
        rst = 1'b1;
        set_btns(3'b000);
        tick();
        rst = 1'b0;
        n_checks++;
        if (o_a !== 8'h00 || o_b !== 8'h00 || o_op !== 6'h00 || o_loaded !== 3'b000 || o_valid !== 1'b0)
            $display("FAIL reset_override: a=%h b=%h op=%h loaded=%b valid=%b want all 0",
                     o_a, o_b, o_op, o_loaded, o_valid);
        else n_pass++;
        for (int k = 0; k < LAT + 6; k++) begin
            tick();
            if (o_valid) vcount++;
        end
        n_checks++;
        if (o_op !== 6'h00 || o_loaded !== 3'b000 || vcount !== 0)
            $display("FAIL reset_override_after: op=%h loaded=%b valid_count=%0d want 00 000 0",
                     o_op, o_loaded, vcount);
        else n_pass++;
        m_a = '0; m_b = '0; m_op = '0; m_loaded = '0;
    endtask

    // Button held through reset release counts as a fresh press.
    task automatic test_reset_held();
        sw = 8'h77;
        btn_a = 1'b1;
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k == LAT) begin
                n_checks++;
                if (o_loaded !== 3'b000)
                    $display("FAIL reset_held_early: loaded=%b want 000", o_loaded);
                else n_pass++;
            end
        end
        n_checks++;
        if (o_a !== 8'h77 || o_loaded !== 3'b001 || o_valid !== 1'b0)
            $display("FAIL reset_held_load: a=%h loaded=%b valid=%b want 77 001 0",
                     o_a, o_loaded, o_valid);
        else n_pass++;
        btn_a = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_simultaneous();
        test_full_set();
        test_reload_same();
        test_held();
        test_random();
`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
        test_bounce();
`endif
        test_reset_override();
        test_reset_held();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
